// File: rtl/lane_serializer.sv
// Registered LANES x W word serializer: captures a packed word by valid/ready,
// then emits one selected lane (single mode) or all lanes with wrap (scan mode).
module lane_serializer #(
   parameter int unsigned W     = 16,
   parameter int unsigned LANES = 16,
   parameter int unsigned SELW  = $clog2(LANES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LANES*W-1:0]   in_data,
   input  logic                 in_mode,
   input  logic [SELW-1:0]      in_sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_data,
   output logic [SELW-1:0]      out_lane,
   output logic                 out_last,
   output logic                 busy
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [SELW:0]   LANE_CNT  = (SELW+1)'(LANES);
   localparam logic [SELW:0]   LAST_CNT  = (SELW+1)'(LANES - 1);
   localparam logic [SELW-1:0] LAST_LANE = SELW'(LANES - 1);

   state_t               state_q, state_d;
   logic [LANES*W-1:0]   word_q, word_d;
   logic                 mode_q, mode_d;
   logic [SELW-1:0]      lane_q, lane_d;
   logic [SELW:0]        cnt_q, cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic                 out_last_q, out_last_d;
   logic [W-1:0]         out_data_q, out_data_d;
   logic                 busy_q, busy_d;

   logic                 accept;
   logic                 xfer;
   logic                 sel_in_range;
   logic [SELW-1:0]      start_lane;
   logic [SELW-1:0]      next_lane;
   logic [SELW:0]        next_cnt;

   // Out-of-range indices match no lane and therefore read as zero.
   function automatic logic [W-1:0] pick_lane(input logic [LANES*W-1:0] word,
                                              input logic [SELW-1:0]    idx);
      logic [W-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (idx == SELW'(k)) r = word[k*W +: W];
      end
      return r;
   endfunction

   assign in_ready     = (state_q == IDLE) && !reset;
   assign accept       = in_valid && in_ready;
   assign xfer         = out_valid_q && out_ready;
   assign sel_in_range = {1'b0, in_sel} < LANE_CNT;

   // Explicit wrap so non-power-of-two lane counts cycle correctly.
   always_comb begin
      start_lane = in_sel;
      if (in_mode && !sel_in_range) start_lane = '0;
      next_lane = (lane_q == LAST_LANE) ? '0 : lane_q + SELW'(1);
      next_cnt  = cnt_q + (SELW+1)'(1);
   end

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      mode_d      = mode_q;
      lane_d      = lane_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               word_d      = in_data;
               mode_d      = in_mode;
               lane_d      = start_lane;
               cnt_d       = '0;
               out_valid_d = 1'b1;
               busy_d      = 1'b1;
               out_data_d  = pick_lane(in_data, start_lane);
               out_last_d  = !in_mode;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = IDLE;
               end else begin
                  lane_d     = next_lane;
                  cnt_d      = next_cnt;
                  out_data_d = pick_lane(word_q, next_lane);
                  out_last_d = mode_q ? (next_cnt == LAST_CNT) : 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         word_q      <= '0;
         mode_q      <= 1'b0;
         lane_q      <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         mode_q      <= mode_d;
         lane_q      <= lane_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_lane  = lane_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer: a 16x16 instance driven from a vector
// table plus hand sequences, and a 5x8 instance for non-power-of-two wrap.
module tb_lane_serializer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int unsigned tests = 0;
   int unsigned fails = 0;

   logic         a_in_valid = 1'b0, a_in_ready, a_in_mode = 1'b0;
   logic [255:0] a_in_data = '0;
   logic [3:0]   a_in_sel = '0, a_out_lane;
   logic         a_out_valid, a_out_ready = 1'b0, a_out_last, a_busy;
   logic [15:0]  a_out_data;

   logic         b_in_valid = 1'b0, b_in_ready, b_in_mode = 1'b0;
   logic [39:0]  b_in_data = 40'h54_53_52_51_50;
   logic [2:0]   b_in_sel = '0, b_out_lane;
   logic         b_out_valid, b_out_ready = 1'b0, b_out_last, b_busy;
   logic [7:0]   b_out_data;

   lane_serializer #(.W(16), .LANES(16)) dut16 (
      .clk(clk), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_mode(a_in_mode), .in_sel(a_in_sel),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_lane(a_out_lane), .out_last(a_out_last), .busy(a_busy)
   );

   lane_serializer #(.W(8), .LANES(5)) dut5 (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_mode(b_in_mode), .in_sel(b_in_sel),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_lane(b_out_lane), .out_last(b_out_last), .busy(b_busy)
   );

   typedef struct {
      logic        mode;
      logic [3:0]  sel;
      int unsigned beats;
      logic [3:0]  first_lane;
      logic [15:0] first_data;
      logic [3:0]  last_lane;
      logic [15:0] last_data;
   } vec_t;

   vec_t vecs[6];

   logic [15:0] got_data[32];
   logic [3:0]  got_lane[32];
   logic        got_last[32];
   int unsigned got_n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] make16(input logic [15:0] base);
      logic [255:0] r;
      for (int unsigned k = 0; k < 16; k++) r[k*16 +: 16] = base + 16'(k);
      return r;
   endfunction

   // Called at a negedge with dut16 idle; returns at a negedge after the word ends.
   task automatic run16(input logic mode, input logic [3:0] sel,
                        input int stall_beat, input int stall_len,
                        input logic [15:0] stall_data, input logic [3:0] stall_lane,
                        input int inject_beat);
      int unsigned cyc;
      int          stalled;
      got_n   = 0;
      stalled = 0;
      cyc     = 0;
      chk("idle_in_ready", 32'(a_in_ready), 32'd1);
      a_in_valid = 1'b1;
      a_in_mode  = mode;
      a_in_sel   = sel;
      @(negedge clk);
      a_in_valid = 1'b0;
      chk("accept_latency", 32'(a_out_valid), 32'd1);
      chk("busy_in_send", 32'(a_busy), 32'd1);
      while (a_out_valid && cyc < 200) begin
         if (int'(got_n) == inject_beat && !a_in_valid) begin
            a_in_valid = 1'b1;
            a_in_data  = make16(16'hB000);
            a_in_mode  = 1'b0;
            a_in_sel   = 4'd7;
            #1;
            chk("send_in_ready_low", 32'(a_in_ready), 32'd0);
         end
         if (int'(got_n) == stall_beat && stalled < stall_len) begin
            a_out_ready = 1'b0;
            chk("stall_data", 32'(a_out_data), 32'(stall_data));
            chk("stall_lane", 32'(a_out_lane), 32'(stall_lane));
            stalled++;
         end else begin
            a_out_ready = 1'b1;
            if (got_n < 32) begin
               got_data[got_n] = a_out_data;
               got_lane[got_n] = a_out_lane;
               got_last[got_n] = a_out_last;
            end
            got_n++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("send_bounded", 32'(cyc < 200), 32'd1);
      chk("end_out_valid", 32'(a_out_valid), 32'd0);
      chk("end_busy", 32'(a_busy), 32'd0);
      chk("end_out_last", 32'(a_out_last), 32'd0);
      chk("end_in_ready", 32'(a_in_ready), 32'd1);
      a_out_ready = 1'b0;
   endtask

   task automatic check16(input int unsigned i);
      logic [3:0] el;
      chk($sformatf("v%0d_beats", i), got_n, vecs[i].beats);
      chk($sformatf("v%0d_first_lane", i), 32'(got_lane[0]), 32'(vecs[i].first_lane));
      chk($sformatf("v%0d_first_data", i), 32'(got_data[0]), 32'(vecs[i].first_data));
      if (got_n >= 1 && got_n <= 32) begin
         chk($sformatf("v%0d_last_lane", i), 32'(got_lane[got_n-1]), 32'(vecs[i].last_lane));
         chk($sformatf("v%0d_last_data", i), 32'(got_data[got_n-1]), 32'(vecs[i].last_data));
      end
      for (int unsigned b = 0; b < got_n && b < 32; b++) begin
         el = vecs[i].first_lane + 4'(b);
         chk($sformatf("v%0d_b%0d_lane", i, b), 32'(got_lane[b]), 32'(el));
         chk($sformatf("v%0d_b%0d_data", i, b), 32'(got_data[b]), 32'(16'hA000 | 16'(el)));
         chk($sformatf("v%0d_b%0d_last", i, b), 32'(got_last[b]), 32'(b == got_n - 1));
      end
   endtask

   task automatic run5(input logic mode, input logic [2:0] sel);
      int unsigned cyc;
      got_n = 0;
      cyc   = 0;
      chk("b_idle_in_ready", 32'(b_in_ready), 32'd1);
      b_in_valid = 1'b1;
      b_in_mode  = mode;
      b_in_sel   = sel;
      @(negedge clk);
      b_in_valid = 1'b0;
      chk("b_accept_latency", 32'(b_out_valid), 32'd1);
      while (b_out_valid && cyc < 100) begin
         b_out_ready = 1'b1;
         if (got_n < 32) begin
            got_data[got_n] = 16'(b_out_data);
            got_lane[got_n] = 4'(b_out_lane);
            got_last[got_n] = b_out_last;
         end
         got_n++;
         @(negedge clk);
         cyc++;
      end
      chk("b_end_out_valid", 32'(b_out_valid), 32'd0);
      chk("b_end_busy", 32'(b_busy), 32'd0);
      b_out_ready = 1'b0;
   endtask

   task automatic check5(input string name, input int unsigned n,
                         input logic [39:0] lanes, input logic [39:0] data,
                         input logic [4:0] lasts);
      chk({name, "_beats"}, got_n, n);
      for (int unsigned b = 0; b < n && b < got_n; b++) begin
         chk($sformatf("%s_b%0d_lane", name, b), 32'(got_lane[b]), 32'(lanes[b*8 +: 8]));
         chk($sformatf("%s_b%0d_data", name, b), 32'(got_data[b]), 32'(data[b*8 +: 8]));
         chk($sformatf("%s_b%0d_last", name, b), 32'(got_last[b]), 32'(lasts[b]));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned cyc;
      vecs[0] = '{1'b0, 4'd5,  1,  4'd5,  16'hA005, 4'd5,  16'hA005};
      vecs[1] = '{1'b1, 4'd14, 16, 4'd14, 16'hA00E, 4'd13, 16'hA00D};
      vecs[2] = '{1'b1, 4'd0,  16, 4'd0,  16'hA000, 4'd15, 16'hA00F};
      vecs[3] = '{1'b0, 4'd15, 1,  4'd15, 16'hA00F, 4'd15, 16'hA00F};
      vecs[4] = '{1'b0, 4'd0,  1,  4'd0,  16'hA000, 4'd0,  16'hA000};
      vecs[5] = '{1'b1, 4'd15, 16, 4'd15, 16'hA00F, 4'd14, 16'hA00E};

      a_in_data = make16(16'hA000);
      @(negedge clk);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_out_last", 32'(a_out_last), 32'd0);
      chk("rst_out_lane", 32'(a_out_lane), 32'd0);
      chk("rst_out_data", 32'(a_out_data), 32'd0);
      chk("rst_in_ready", 32'(a_in_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);
      @(negedge clk);

      for (int unsigned i = 0; i < 6; i++) begin
         run16(vecs[i].mode, vecs[i].sel, -1, 0, 16'h0, 4'h0, -1);
         check16(i);
         @(negedge clk);
      end

      // Backpressure: three stalled cycles at beat 2 of a scan from lane 0.
      run16(1'b1, 4'd0, 2, 3, 16'hA002, 4'd2, -1);
      check16(2);
      @(negedge clk);

      // New word offered mid-scan must wait for IDLE, then be taken.
      run16(1'b1, 4'd0, -1, 0, 16'h0, 4'h0, 4);
      check16(2);
      @(negedge clk);
      a_in_valid = 1'b0;
      chk("late_word_valid", 32'(a_out_valid), 32'd1);
      chk("late_word_data", 32'(a_out_data), 32'h0000B007);
      chk("late_word_lane", 32'(a_out_lane), 32'd7);
      chk("late_word_last", 32'(a_out_last), 32'd1);
      a_out_ready = 1'b1;
      @(negedge clk);
      chk("late_word_done", 32'(a_out_valid), 32'd0);
      a_out_ready = 1'b0;
      a_in_data = make16(16'hA000);
      @(negedge clk);

      // Reset asserted between edges at beat 6 of a scan.
      a_in_valid  = 1'b1;
      a_in_mode   = 1'b1;
      a_in_sel    = 4'd0;
      a_out_ready = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      cyc = 0;
      while (a_out_lane != 4'd6 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("reach_beat6", 32'(a_out_lane), 32'd6);
      #2 reset = 1'b1;
      #1;
      chk("abort_out_valid", 32'(a_out_valid), 32'd0);
      chk("abort_busy", 32'(a_busy), 32'd0);
      chk("abort_in_ready", 32'(a_in_ready), 32'd0);
      chk("abort_out_lane", 32'(a_out_lane), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      a_out_ready = 1'b0;
      #1;
      chk("release_in_ready", 32'(a_in_ready), 32'd1);
      @(negedge clk);
      run16(1'b0, 4'd3, -1, 0, 16'h0, 4'h0, -1);
      chk("after_rst_beats", got_n, 32'd1);
      chk("after_rst_data", 32'(got_data[0]), 32'h0000A003);
      chk("after_rst_last", 32'(got_last[0]), 32'd1);
      @(negedge clk);

      run5(1'b1, 3'd3);
      check5("b_scan3", 5, 40'h02_01_00_04_03, 40'h52_51_50_54_53, 5'b10000);
      @(negedge clk);
      run5(1'b0, 3'd6);
      check5("b_single6", 1, 40'h06, 40'h00, 5'b00001);
      @(negedge clk);
      run5(1'b1, 3'd6);
      check5("b_scan6", 5, 40'h04_03_02_01_00, 40'h54_53_52_51_50, 5'b10000);
      @(negedge clk);
      run5(1'b0, 3'd4);
      check5("b_single4", 1, 40'h04, 40'h54, 5'b00001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lane_serializer.md
Name: lane_serializer

Overview:
- Parametrised, registered successor to the team's 16:1 lane mux.
- Captures a LANES×W-bit word through a valid/ready handshake. Then emits either one selected lane (single mode) or every lane in sequence, starting from a chosen lane and wrapping (scan mode).
- Sits between wide datapath results (e.g. 256-bit lane-packed ALU output) and narrow W-bit consumers such as display or serial logic.

Parameters:
- W, 16, lane width in bits (≥1)
- LANES, 16, number of lanes in the input word (≥2; need not be a power of two)
- SELW, $clog2(LANES), lane-index width (derived; not overridden)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  producer offers in_data/in_mode/in_sel
- in_ready  output  1  block can accept a new word
- in_data  input  LANES*W  packed lanes; lane k = in_data[k*W +: W]
- in_mode  input  1  0 = single lane, 1 = scan all lanes
- in_sel  input  SELW  single: lane to emit; scan: start lane
- out_valid  output  1  out_data/out_lane/out_last are valid
- out_ready  input  1  consumer accepts the current beat
- out_data  output  W  current lane data
- out_lane  output  SELW  index of the current lane
- out_last  output  1  current beat is the final beat of the word
- busy  output  1  a captured word is still being emitted

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Reset values: state = IDLE; out_valid = 0; out_last = 0; out_lane = 0; out_data = 0; busy = 0; internal data, lane and count registers = 0. in_ready is forced to 0 while reset is high.
- States: IDLE and SEND.
- IDLE:
  - in_ready = 1.
  - Accept when in_valid && in_ready. On accept, register in_data, in_mode and in_sel. Set lane index = in_sel (values ≥ LANES are replaced by 0 in scan mode). Set beat count = 0. Go to SEND.
- Latency: out_valid rises on the clock edge after accept (1 cycle). No combinational path from in_* to out_*.
- SEND:
  - in_ready = 0; busy = 1; out_valid = 1.
  - out_data = registered word[lane*W +: W]. out_lane = lane.
- Output transfer: occurs when out_valid && out_ready. While out_valid && !out_ready, out_data, out_lane and out_last hold stable.
- Single mode: exactly one beat with out_last = 1. If in_sel ≥ LANES, out_data = 0 and out_lane = in_sel as captured.
- Scan mode:
  - Exactly LANES beats. out_last = 1 only when count == LANES-1.
  - After each transfer: lane ← (lane == LANES-1) ? 0 : lane+1; count ← count+1.
- End of word: after the transfer of the out_last beat, go to IDLE on the next edge. out_valid, busy and out_last drop to 0, and in_ready returns to 1. There is no overlap: a new word is never accepted in the same cycle as the last beat.
- in_valid while in SEND is ignored, and the producer must hold its data.
- Reset mid-SEND aborts the word immediately, with no further beats. The bench verifies that out_valid drops asynchronously.
- Width rules: count is SELW+1 bits wide so LANES = 2^SELW terminates correctly. Lane index wrap is explicit, not a power-of-two truncation.

Test Plan:
- Single, W=16, LANES=16: in_data lane k = 16'hA000+k, mode=0, sel=5 → one beat 1 cycle after accept: out_data=16'hA005, out_lane=5, out_last=1; then IDLE, in_ready=1.
- Scan with wrap: same data, mode=1, sel=14, out_ready=1 → 16 consecutive beats, lanes 14,15,0,1,…,13; out_data=16'hA00E,16'hA00F,16'hA000,…,16'hA00D; out_last only on lane 13.
- Backpressure: scan, sel=0; hold out_ready=0 for 3 cycles at beat 2 → out_data=16'hA002 and out_lane=2 held stable; no beat lost or duplicated; 16 total beats.
- Busy rejection: assert in_valid with new data during SEND → in_ready=0, no capture, the current word completes unchanged; new word accepted only after return to IDLE.
- Reset mid-scan: assert reset at beat 6 → out_valid=0, busy=0 asynchronously; after release in_ready=1 and a fresh single-mode word (sel=3) yields 16'hA003.
- Non-power-of-two, LANES=5, W=8: scan sel=3 → lanes 3,4,0,1,2, last on lane 2. Single with sel=6 → out_data=8'h00, out_last=1.
